// File: rtl/gpu_core_pkg.sv
// Shared definitions for the SIMT core: pipeline state codes, the
// constant-register layout at the top of each lane bank, and clear FSM states.
package gpu_core_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    localparam int unsigned CONST_REG_COUNT = 3;

    typedef enum logic {
        CLR_READY = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // Constant registers occupy the top three slots of every bank.
    function automatic int unsigned block_id_reg(input int unsigned num_regs);
        return num_regs - CONST_REG_COUNT;
    endfunction

    function automatic int unsigned thread_id_reg(input int unsigned num_regs);
        return num_regs - 2;
    endfunction

    function automatic int unsigned threads_pb_reg(input int unsigned num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/simt_register_file_lane_bank.sv
// One lane's register bank: two combinational read ports and three write
// sources (sweep clear, constant load, masked general write).
module register_lane_bank
    import gpu_core_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic              const_en,
    input  logic [DATA_W-1:0] block_id,
    input  logic [DATA_W-1:0] thread_id,
    input  logic [DATA_W-1:0] threads_pb,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam logic [ADDR_W-1:0] BID_REG = ADDR_W'(block_id_reg(NUM_REGS));
    localparam logic [ADDR_W-1:0] TID_REG = ADDR_W'(thread_id_reg(NUM_REGS));
    localparam logic [ADDR_W-1:0] TPB_REG = ADDR_W'(threads_pb_reg(NUM_REGS));

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr < BID_REG)) begin
            regs_d[wr_addr] = wr_data;
        end
        // Sweep and general write never overlap at the top; sweep still wins here.
        if (clr_en && (clr_idx < BID_REG)) begin
            regs_d[clr_idx] = '0;
        end
        if (const_en) begin
            regs_d[BID_REG] = block_id;
            regs_d[TID_REG] = thread_id;
            regs_d[TPB_REG] = threads_pb;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data1 = regs_q[rd_addr1];
    assign rd_data2 = regs_q[rd_addr2];

endmodule

// File: rtl/simt_register_file.sv
// Per-lane SIMT register file: NUM_THREADS lane banks sharing addresses,
// plus the soft-clear sequencer and the sticky write-protect flag.
module simt_register_file
    import gpu_core_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned NUM_THREADS   = 4,
    parameter logic [2:0]  REQUEST_STATE = 3'(CORE_REQUEST),
    parameter logic [2:0]  UPDATE_STATE  = 3'(CORE_UPDATE)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [2:0]                      core_state,
    input  logic [DATA_W-1:0]               block_id,
    input  logic [DATA_W-1:0]               thread_base,
    input  logic [DATA_W-1:0]               threads_per_block,
    input  logic                            clear,
    input  logic [$clog2(NUM_REGS)-1:0]     read_addr1,
    input  logic [$clog2(NUM_REGS)-1:0]     read_addr2,
    input  logic [$clog2(NUM_REGS)-1:0]     write_addr,
    input  logic                            write_enable,
    input  logic [NUM_THREADS-1:0]          lane_mask,
    input  logic [NUM_THREADS*DATA_W-1:0]   write_data,
    output logic [NUM_THREADS*DATA_W-1:0]   read_data1,
    output logic [NUM_THREADS*DATA_W-1:0]   read_data2,
    output logic                            busy,
    output logic                            wr_protect_err
);

    localparam int unsigned       ADDR_W         = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] BLOCK_ID_REG   = ADDR_W'(block_id_reg(NUM_REGS));
    localparam logic [ADDR_W-1:0] LAST_CLEAR_IDX = ADDR_W'(block_id_reg(NUM_REGS) - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;
    logic              err_q, err_d;

    logic wr_qual;
    logic wr_prot;
    logic wr_commit;
    logic const_en;
    logic sweep_en;

    assign busy           = (state_q == CLR_CLEAR);
    assign wr_protect_err = err_q;

    // A clear pulse pre-empts any write in the same cycle.
    assign wr_qual   = enable && (core_state == UPDATE_STATE) && write_enable && !busy && !clear;
    assign wr_prot   = wr_qual && (write_addr >= BLOCK_ID_REG);
    assign wr_commit = wr_qual && !wr_prot;
    assign const_en  = enable && (core_state == REQUEST_STATE);
    assign sweep_en  = busy && !clear;

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        err_d       = err_q;

        case (state_q)
            CLR_READY: begin
                if (clear) begin
                    state_d     = CLR_CLEAR;
                    clear_idx_d = '0;
                end
            end
            CLR_CLEAR: begin
                if (clear) begin
                    clear_idx_d = '0;
                end else if (clear_idx_q == LAST_CLEAR_IDX) begin
                    state_d     = CLR_READY;
                    clear_idx_d = '0;
                end else begin
                    clear_idx_d = clear_idx_q + 1'b1;
                end
            end
            default: begin
                state_d     = CLR_READY;
                clear_idx_d = '0;
            end
        endcase

        if (clear) begin
            err_d = 1'b0;
        end else if (wr_prot) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLR_READY;
            clear_idx_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            err_q       <= err_d;
        end
    end

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
        logic [DATA_W-1:0] thread_id;
        assign thread_id = thread_base + DATA_W'(t);

        register_lane_bank #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) u_bank (
            .clk        (clk),
            .reset_n    (reset_n),
            .clr_en     (sweep_en),
            .clr_idx    (clear_idx_q),
            .const_en   (const_en),
            .block_id   (block_id),
            .thread_id  (thread_id),
            .threads_pb (threads_per_block),
            .wr_en      (wr_commit && lane_mask[t]),
            .wr_addr    (write_addr),
            .wr_data    (write_data[t*DATA_W +: DATA_W]),
            .rd_addr1   (read_addr1),
            .rd_addr2   (read_addr2),
            .rd_data1   (read_data1[t*DATA_W +: DATA_W]),
            .rd_data2   (read_data2[t*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_simt_register_file.sv
// Directed bench for simt_register_file with an array-based reference model
// checked on every falling edge, plus literal spot checks.
module tb_simt_register_file;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int NT = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable = 1'b0;
    logic [2:0]    core_state = 3'b000;
    logic [DW-1:0] block_id = '0;
    logic [DW-1:0] thread_base = '0;
    logic [DW-1:0] threads_per_block = '0;
    logic          clear = 1'b0;
    logic [AW-1:0] read_addr1 = '0;
    logic [AW-1:0] read_addr2 = '0;
    logic [AW-1:0] write_addr = '0;
    logic          write_enable = 1'b0;
    logic [NT-1:0] lane_mask = '0;
    logic [NT*DW-1:0] write_data = '0;
    logic [NT*DW-1:0] read_data1;
    logic [NT*DW-1:0] read_data2;
    logic          busy;
    logic          wr_protect_err;

    always #5 clk = ~clk;

    simt_register_file #(
        .DATA_W        (DW),
        .NUM_REGS      (NR),
        .NUM_THREADS   (NT),
        .REQUEST_STATE (3'b011),
        .UPDATE_STATE  (3'b110)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .core_state        (core_state),
        .block_id          (block_id),
        .thread_base       (thread_base),
        .threads_per_block (threads_per_block),
        .clear             (clear),
        .read_addr1        (read_addr1),
        .read_addr2        (read_addr2),
        .write_addr        (write_addr),
        .write_enable      (write_enable),
        .lane_mask         (lane_mask),
        .write_data        (write_data),
        .read_data1        (read_data1),
        .read_data2        (read_data2),
        .busy              (busy),
        .wr_protect_err    (wr_protect_err)
    );

    int ntests = 0;
    int nfail  = 0;

    // Reference model: plain register arrays plus a sweep position counter.
    logic [DW-1:0] m_mem [NT][NR];
    bit            m_busy;
    int            m_pos;
    bit            m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [NT*DW-1:0] bus, input int t);
        return bus[t*DW +: DW];
    endfunction

    task automatic model_zero();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < NR; r++)
                m_mem[t][r] = '0;
        m_busy = 0;
        m_pos  = 0;
        m_err  = 0;
    endtask

    initial begin
        model_zero();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_zero();
            end else begin
                bit wr_ok;
                wr_ok = enable && core_state == 3'b110 && write_enable && !m_busy && !clear;
                if (wr_ok) begin
                    if (int'(write_addr) >= NR - 3) m_err = 1;
                    else
                        for (int t = 0; t < NT; t++)
                            if (lane_mask[t]) m_mem[t][write_addr] = lane(write_data, t);
                end
                if (enable && core_state == 3'b011)
                    for (int t = 0; t < NT; t++) begin
                        m_mem[t][NR-3] = block_id;
                        m_mem[t][NR-2] = DW'(int'(thread_base) + t);
                        m_mem[t][NR-1] = threads_per_block;
                    end
                if (clear) begin
                    m_busy = 1;
                    m_pos  = 0;
                    m_err  = 0;
                end else if (m_busy) begin
                    for (int t = 0; t < NT; t++) m_mem[t][m_pos] = '0;
                    m_pos++;
                    if (m_pos == NR - 3) m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int t = 0; t < NT; t++) begin
            chk($sformatf("model_rd1 lane%0d reg%0d", t, read_addr1), lane(read_data1, t), m_mem[t][read_addr1]);
            chk($sformatf("model_rd2 lane%0d reg%0d", t, read_addr2), lane(read_data2, t), m_mem[t][read_addr2]);
        end
        chk("model_busy", busy, m_busy);
        chk("model_err", wr_protect_err, m_err);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload();
        core_state   = 3'b110;
        write_enable = 1'b1;
        lane_mask    = 4'b1111;
        for (int a = 0; a < NR - 3; a++) begin
            write_addr = AW'(a);
            write_data = {8'(a + 8'h40), 8'(a + 8'h30), 8'(a + 8'h20), 8'(a + 8'h10)};
            tick();
        end
        write_enable = 1'b0;
        core_state   = 3'b000;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        enable = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_err", wr_protect_err, 0);
        chk("reset_rd1", read_data1, 0);

        // Constant load
        core_state = 3'b011; block_id = 8'd5; thread_base = 8'd8; threads_per_block = 8'd4;
        tick();
        core_state = 3'b000;
        read_addr1 = 4'd14; read_addr2 = 4'd13;
        #1;
        for (int t = 0; t < NT; t++) begin
            chk("const_tid", lane(read_data1, t), 8 + t);
            chk("const_bid", lane(read_data2, t), 5);
        end
        read_addr2 = 4'd15;
        #1 chk("const_tpb_lane3", lane(read_data2, 3), 4);
        for (int a = 0; a < NR; a++) begin
            read_addr1 = AW'(a);
            tick();
        end

        // Masked write
        core_state = 3'b110; write_enable = 1'b1; write_addr = 4'd3;
        lane_mask = 4'b0101; write_data = 32'h44332211; read_addr1 = 4'd3;
        #1 chk("mask_before_edge", lane(read_data1, 0), 0);
        tick();
        write_enable = 1'b0; core_state = 3'b000;
        #1;
        chk("mask_lane0", lane(read_data1, 0), 8'h11);
        chk("mask_lane1", lane(read_data1, 1), 8'h00);
        chk("mask_lane2", lane(read_data1, 2), 8'h33);
        chk("mask_lane3", lane(read_data1, 3), 8'h00);

        // Ignored and protected writes
        lane_mask = 4'b1111; write_data = 32'hAAAAAAAA;
        enable = 1'b0; core_state = 3'b110; write_enable = 1'b1; write_addr = 4'd13;
        tick();
        enable = 1'b1; core_state = 3'b101;
        tick();
        read_addr1 = 4'd13;
        #1 chk("disabled_err", wr_protect_err, 0);
        chk("disabled_reg13", lane(read_data1, 0), 5);
        core_state = 3'b110; write_addr = 4'd14; read_addr1 = 4'd14;
        tick();
        write_enable = 1'b0; core_state = 3'b000;
        #1 chk("prot_err", wr_protect_err, 1);
        chk("prot_reg14_lane1", lane(read_data1, 1), 9);
        tick(); tick();
        chk("prot_err_sticky", wr_protect_err, 1);

        // Soft clear with a write on the 5th busy cycle
        preload();
        read_addr1 = 4'd2; read_addr2 = 4'd12;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 5) begin
                core_state = 3'b110; write_enable = 1'b1; write_addr = 4'd2; write_data = 32'hFFFFFFFF;
            end else begin
                core_state = 3'b000; write_enable = 1'b0;
            end
            tick();
        end
        core_state = 3'b000; write_enable = 1'b0;
        chk("clear_busy_cycles", n, 13);
        chk("clear_err", wr_protect_err, 0);
        #1 chk("clear_reg2_lane0", lane(read_data1, 0), 0);
        chk("clear_reg12_lane3", lane(read_data2, 3), 0);
        read_addr1 = 4'd13; read_addr2 = 4'd14;
        #1 chk("clear_keep_bid", lane(read_data1, 2), 5);
        chk("clear_keep_tid", lane(read_data2, 3), 11);
        for (int a = 0; a < NR; a++) begin
            read_addr1 = AW'(a);
            tick();
        end

        // Restart at sweep index 6, colliding with a write
        preload();
        read_addr1 = 4'd1; read_addr2 = 4'd6;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (busy && n < 7) begin
            n++;
            if (n == 7) begin
                clear = 1'b1; core_state = 3'b110; write_enable = 1'b1;
                write_addr = 4'd1; write_data = 32'h77777777;
            end
            tick();
        end
        clear = 1'b0; write_enable = 1'b0; core_state = 3'b000;
        chk("restart_reached", n, 7);
        #1 chk("collide_dropped", lane(read_data1, 0), 0);
        chk("restart_reg6_lane0", lane(read_data2, 0), 8'h16);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("restart_busy_cycles", n, 13);

        // Async reset mid-sweep
        preload();
        read_addr1 = 4'd13; read_addr2 = 4'd10;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(); tick(); tick();
        #1 reset_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_rd1", read_data1, 0);
        chk("async_rd2", read_data2, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Thread id wrap
        core_state = 3'b011; block_id = 8'd1; thread_base = 8'hFE; threads_per_block = 8'd4;
        tick();
        core_state = 3'b000; read_addr1 = 4'd14;
        #1;
        chk("wrap_lane0", lane(read_data1, 0), 8'hFE);
        chk("wrap_lane1", lane(read_data1, 1), 8'hFF);
        chk("wrap_lane2", lane(read_data1, 2), 8'h00);
        chk("wrap_lane3", lane(read_data1, 3), 8'h01);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
